rob_multi_wb: RTL

//  Parametrised reorder buffer: next generation of the core's in-order commit queue.

---
 rtl/rob_multi_wb_if.sv | 53 +++++
 rtl/rob_multi_wb.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rob_multi_wb_if.sv
// Bundle of issue, write-back, lookup and commit signals around the reorder buffer.
// The environment drives through master; the ROB itself binds to slave.
interface rob_multi_wb_if #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WB_PORTS       = 2,
    parameter int LOOKUP_PORTS   = 2
);
    // Handshakes: issue transfers when issue_valid && issue_ready in the same cycle;
    // a store commit transfers when commit_store is high, which already implies store_ready.
    logic                           issue_valid;
    logic                           issue_ready;
    logic [Q_WIDTH-1:0]             issue_tag;
    logic                           issue_is_store;
    logic                           issue_is_branch;
    logic [REG_ADDR_WIDTH-1:0]      issue_rd;
    logic [31:0]                    issue_pc;
    logic [31:0]                    issue_pred_pc;
    logic [WB_PORTS-1:0]            wb_valid;
    logic [WB_PORTS*Q_WIDTH-1:0]    wb_tag;
    logic [WB_PORTS*32-1:0]         wb_value;
    logic [WB_PORTS*32-1:0]         wb_npc;
    logic [LOOKUP_PORTS*Q_WIDTH-1:0] lk_tag;
    logic [LOOKUP_PORTS-1:0]        lk_hit;
    logic [LOOKUP_PORTS*32-1:0]     lk_value;
    logic                           commit_valid;
    logic [Q_WIDTH-1:0]             commit_tag;
    logic                           commit_we;
    logic [REG_ADDR_WIDTH-1:0]      commit_rd;
    logic [31:0]                    commit_value;
    logic                           commit_store;
    logic                           store_ready;
    logic                           redirect;
    logic [31:0]                    redirect_pc;
    logic [Q_WIDTH-1:0]             count;
    logic                           empty;

    modport master (
        output issue_valid, issue_is_store, issue_is_branch, issue_rd, issue_pc, issue_pred_pc,
        output wb_valid, wb_tag, wb_value, wb_npc, lk_tag, store_ready,
        input  issue_ready, issue_tag, lk_hit, lk_value,
        input  commit_valid, commit_tag, commit_we, commit_rd, commit_value, commit_store,
        input  redirect, redirect_pc, count, empty
    );

    modport slave (
        input  issue_valid, issue_is_store, issue_is_branch, issue_rd, issue_pc, issue_pred_pc,
        input  wb_valid, wb_tag, wb_value, wb_npc, lk_tag, store_ready,
        output issue_ready, issue_tag, lk_hit, lk_value,
        output commit_valid, commit_tag, commit_we, commit_rd, commit_value, commit_store,
        output redirect, redirect_pc, count, empty
    );
endinterface

// File: rtl/rob_multi_wb.sv
// In-order commit queue with multiple write-back channels, bypassing operand lookups,
// store-commit handshake, mispredict redirect and external flush.
module rob_multi_wb #(
    parameter int Q_WIDTH        = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WB_PORTS       = 2,
    parameter int LOOKUP_PORTS   = 2
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    rob_multi_wb_if.slave bus
);
    localparam int DEPTH = 1 << Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] MAX_TAG = '1;
    localparam logic [Q_WIDTH-1:0] ONE_TAG = {{(Q_WIDTH-1){1'b0}}, 1'b1};

    logic [Q_WIDTH-1:0]        head_q, tail_q, count_q, count_next;
    logic                      full_q;
    logic [DEPTH-1:0]          done_q, store_q, branch_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q    [DEPTH];
    logic [31:0]               pred_q  [DEPTH];
    logic [31:0]               value_q [DEPTH];
    logic [31:0]               npc_q   [DEPTH];

    logic alloc, retire, mispredict, do_redirect, clear;

    // Tag 0 means "no tag", so the sequence skips it on wrap.
    function automatic logic [Q_WIDTH-1:0] next_tag(input logic [Q_WIDTH-1:0] t);
        return (t == MAX_TAG) ? ONE_TAG : t + ONE_TAG;
    endfunction

    assign retire      = rdy_in && (count_q != '0) && done_q[head_q] &&
                         (!store_q[head_q] || bus.store_ready);
    assign alloc       = rdy_in && bus.issue_valid && !full_q;
    assign mispredict  = branch_q[head_q] && (npc_q[head_q] != pred_q[head_q]);
    assign do_redirect = retire && mispredict;
    assign clear       = rdy_in && (flush_in || do_redirect);

    always_comb begin
        count_next = count_q;
        if (alloc && !retire)
            count_next = count_q + ONE_TAG;
        else if (retire && !alloc)
            count_next = count_q - ONE_TAG;
    end

    assign bus.issue_ready  = !full_q;
    assign bus.issue_tag    = tail_q;
    assign bus.commit_valid = retire;
    assign bus.commit_tag   = head_q;
    assign bus.commit_we    = retire && !store_q[head_q] && !branch_q[head_q] &&
                              (rd_q[head_q] != '0);
    assign bus.commit_rd    = rd_q[head_q];
    assign bus.commit_value = value_q[head_q];
    assign bus.commit_store = retire && store_q[head_q];
    assign bus.redirect     = do_redirect;
    assign bus.redirect_pc  = npc_q[head_q];
    assign bus.count        = count_q;
    assign bus.empty        = (count_q == '0);

    // Lookup: a completed slot wins; otherwise the lowest-index write-back channel bypasses.
    always_comb begin
        logic [Q_WIDTH-1:0] lt;
        lt           = '0;
        bus.lk_hit   = '0;
        bus.lk_value = '0;
        for (int l = 0; l < LOOKUP_PORTS; l++) begin
            lt = bus.lk_tag[l*Q_WIDTH +: Q_WIDTH];
            if (lt != '0) begin
                if (done_q[lt]) begin
                    bus.lk_hit[l]            = 1'b1;
                    bus.lk_value[l*32 +: 32] = value_q[lt];
                end else begin
                    for (int w = WB_PORTS - 1; w >= 0; w--) begin
                        if (bus.wb_valid[w] && (bus.wb_tag[w*Q_WIDTH +: Q_WIDTH] == lt)) begin
                            bus.lk_hit[l]            = 1'b1;
                            bus.lk_value[l*32 +: 32] = bus.wb_value[w*32 +: 32];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear) begin
            head_q   <= ONE_TAG;
            tail_q   <= ONE_TAG;
            count_q  <= '0;
            full_q   <= 1'b0;
            done_q   <= '0;
            store_q  <= '0;
            branch_q <= '0;
        end else if (rdy_in) begin
            if (alloc) begin
                rd_q[tail_q]     <= bus.issue_rd;
                pred_q[tail_q]   <= bus.issue_pred_pc;
                store_q[tail_q]  <= bus.issue_is_store;
                branch_q[tail_q] <= bus.issue_is_branch;
                done_q[tail_q]   <= 1'b0;
                tail_q           <= next_tag(tail_q);
            end
            if (retire) begin
                done_q[head_q] <= 1'b0;
                head_q         <= next_tag(head_q);
            end
            // Ascending loop: a later channel's write overrides an earlier one to the same tag.
            for (int w = 0; w < WB_PORTS; w++) begin
                if (bus.wb_valid[w] && (bus.wb_tag[w*Q_WIDTH +: Q_WIDTH] != '0)) begin
                    value_q[bus.wb_tag[w*Q_WIDTH +: Q_WIDTH]] <= bus.wb_value[w*32 +: 32];
                    npc_q[bus.wb_tag[w*Q_WIDTH +: Q_WIDTH]]   <= bus.wb_npc[w*32 +: 32];
                    done_q[bus.wb_tag[w*Q_WIDTH +: Q_WIDTH]]  <= 1'b1;
                end
            end
            count_q <= count_next;
            full_q  <= (count_next == MAX_TAG);
        end
    end
endmodule
